parity_frame_checker: RTL and testbench
=======================================

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the number of data bits per frame (legal range 1..16).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_x, input, 1 bit: serial line bit, sampled only when i_bit_vld=1.
REQ-005 SHALL have port i_bit_vld, input, 1 bit: qualifies i_x; one bit is consumed per qualified cycle.
REQ-006 SHALL have port o_data, output, DATA_W bits: last received data word.
REQ-007 SHALL have port o_data_vld, output, 1 bit: one-cycle pulse marking a completed frame.
REQ-008 SHALL have port o_par_err, output, 1 bit: even-parity failure on the last completed frame.
REQ-009 SHALL have port o_frame_err, output, 1 bit: stop-bit failure on the last completed frame.
REQ-010 SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL use the frame format: start bit 0, then DATA_W data bits LSB first, then 1 parity bit, then 1 stop bit of value 1.
REQ-012 SHALL treat a frame as correct when the count of ones over data plus parity is even.
REQ-013 SHALL implement a Moore FSM with states IDLE, DATA, PAR and STOP; all transitions occur only on cycles where i_bit_vld=1.
REQ-014 SHALL handle IDLE as follows:
- qualified i_x=0 moves to DATA, clearing the bit counter and the running parity;
- qualified i_x=1 stays in IDLE (line idle).
REQ-015 SHALL handle DATA as follows:
- shift i_x into bit position (count) of the shift register;
- XOR i_x into the running parity;
- after DATA_W qualified bits, move to PAR.
REQ-016 SHALL, in PAR, register the parity error as (running parity XOR i_x) and move to STOP.
REQ-017 SHALL, on a qualified stop bit, load o_data from the shift register, update o_par_err and o_frame_err, pulse o_data_vld high for exactly one cycle on the next clock edge, and return to IDLE.
REQ-018 SHALL hold o_data, o_par_err and o_frame_err stable between o_data_vld pulses.
REQ-019 SHALL report frame latency as o_data_vld asserted on the first rising edge after the cycle in which the stop bit is qualified.
REQ-020 SHALL make cycles with i_bit_vld=0 mid-frame pure stalls: no state, counter or output change.
REQ-021 SHALL accept back-to-back frames: a start bit qualified in the cycle immediately after the stop bit is accepted, and no idle bit is required.
REQ-022 SHALL pulse o_data_vld even when o_par_err or o_frame_err is set; the data is still delivered.
REQ-023 SHALL size the bit counter to clog2(DATA_W+1) bits and never let it wrap within a frame.

Reset
REQ-024 SHALL, while i_rst_n=0, asynchronously force:
- state to IDLE;
- counter, shift register and running parity to 0;
- o_data to 0, o_data_vld to 0, o_par_err to 0, o_frame_err to 0, o_busy to 0.
REQ-025 SHALL discard a partial frame when reset is applied mid-frame, with no o_data_vld pulse; after release it waits for a new start bit.
REQ-026 SHALL synchronise reset deassertion externally; the block itself adds no synchronizer.

Configuration
REQ-027 SHALL, with macro PARITY_FRAME_CHECK_STOP_EN defined, set o_frame_err=1 when the qualified stop bit is 0.
REQ-028 SHALL, without PARITY_FRAME_CHECK_STOP_EN, accept the stop bit regardless of value and tie o_frame_err to constant 0.

Structure
REQ-029 SHALL place the FSM state enum (IDLE/DATA/PAR/STOP) and the default DATA_W constant in shared package parity_pkg.
REQ-030 SHALL implement the serial-to-parallel register with write-enable and bit index as one sub-module, sipo_shift; the FSM, counter and parity logic stay in the top module.

Verification
REQ-031 SHALL verify a clean frame: DATA_W=8, send 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1) -> o_data=8'hA5, o_par_err=0, o_frame_err=0, one o_data_vld pulse.
REQ-032 SHALL verify a parity error: same frame with parity bit 1 -> o_data=8'hA5, o_par_err=1, o_data_vld pulses.
REQ-033 SHALL verify stop-bit handling: stop bit 0 with macro defined -> o_frame_err=1; without macro -> o_frame_err=0.
REQ-034 SHALL verify stalls: the 0xA5 frame with i_bit_vld=0 inserted for 3 cycles after data bit 4 -> identical result, o_busy high throughout the stall.
REQ-035 SHALL verify reset mid-frame: drive i_rst_n=0 after 5 data bits, then send a full 0x3C frame -> only one o_data_vld, with o_data=8'h3C.
REQ-036 SHALL verify back-to-back frames: send frames 0x01 then 0xFF with no gap -> two o_data_vld pulses 11 qualified bits apart, both with o_par_err=0.

Source files
------------

// File: rtl/parity_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : parity_pkg                                                   |
// | Description : Shared definitions for the serial parity frame checker:      |
// |               receive FSM state encoding and the default data width.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package parity_pkg;

    // Default number of data bits per frame.
    localparam int c_default_data_w = 8;

    // Receive FSM states: waiting for start, data bits, parity bit, stop bit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

endpackage : parity_pkg
`default_nettype wire

// File: rtl/parity_frame_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : parity_frame_checker_if                                      |
// | Description : Serial line input and parallel frame result bundle.         |
// |   i_x         - serial line bit (valid when i_bit_vld = 1)                 |
// |   i_bit_vld   - qualifies i_x, one bit consumed per qualified cycle        |
// |   o_data      - last received data word                                    |
// |   o_data_vld  - one-cycle pulse marking a completed frame                  |
// |   o_par_err   - even-parity failure on the last completed frame            |
// |   o_frame_err - stop-bit failure on the last completed frame               |
// |   o_busy      - receiver is inside a frame                                 |
// |   Modports: master (line source / result sink), slave (the checker).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface parity_frame_checker_if
    import parity_pkg::*;
#(
    parameter int DATA_W = c_default_data_w
) ();

    logic              i_x;
    logic              i_bit_vld;
    logic [DATA_W-1:0] o_data;
    logic              o_data_vld;
    logic              o_par_err;
    logic              o_frame_err;
    logic              o_busy;

    modport master (
        output i_x,
        output i_bit_vld,
        input  o_data,
        input  o_data_vld,
        input  o_par_err,
        input  o_frame_err,
        input  o_busy
    );

    modport slave (
        input  i_x,
        input  i_bit_vld,
        output o_data,
        output o_data_vld,
        output o_par_err,
        output o_frame_err,
        output o_busy
    );

endinterface : parity_frame_checker_if
`default_nettype wire

// File: rtl/sipo_shift.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sipo_shift                                                   |
// | Description : Serial-to-parallel register. When i_wr_en is high, i_bit is  |
// |               written into bit position i_idx of the word.                 |
// |   i_clk, i_rst_n - clock and asynchronous active-low reset                |
// |   i_wr_en        - write enable                                           |
// |   i_idx          - target bit position (0 = LSB)                          |
// |   i_bit          - bit value to store                                     |
// |   o_word         - assembled parallel word                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sipo_shift #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst_n,
    input  wire logic              i_wr_en,
    input  wire logic [IDX_W-1:0]  i_idx,
    input  wire logic              i_bit,
    output logic      [DATA_W-1:0] o_word
);

    logic [DATA_W-1:0] r_word;

    // Per-bit decode keeps the index width independent of the word width;
    // the index may carry one more bit than strictly needed to address DATA_W.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= '0;
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                if (i_wr_en && (i_idx == IDX_W'(i))) begin
                    r_word[i] <= i_bit;
                end
            end
        end
    end

    assign o_word = r_word;

endmodule : sipo_shift
`default_nettype wire

// File: rtl/parity_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : parity_frame_checker                                         |
// | Description : Receives frames of {start 0, DATA_W data bits LSB first,     |
// |               even parity bit, stop bit 1} from a qualified serial line   |
// |               and reports the word with parity and framing status.        |
// |   i_clk   - clock, all state changes on the rising edge                   |
// |   i_rst_n - asynchronous active-low reset (deassertion synchronised       |
// |             externally)                                                   |
// |   bus     - parity_frame_checker_if.slave (line in, frame result out)     |
// | Build option: define PARITY_FRAME_CHECK_STOP_EN to flag a 0 stop bit on   |
// |               o_frame_err; otherwise o_frame_err is tied to 0.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = c_default_data_w
) (
    input wire logic               i_clk,
    input wire logic               i_rst_n,
    parity_frame_checker_if.slave  bus
);

    // Counter must hold DATA_W itself so it never wraps inside a frame.
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_shift_en;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_par;
    logic               r_par_err_pend;
    logic [DATA_W-1:0]  w_word;
    logic [DATA_W-1:0]  r_data;
    logic               r_data_vld;
    logic               r_par_err;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Every transition is gated by i_bit_vld, so unqualified cycles stall.
    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_bit_vld && !bus.i_x) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (bus.i_bit_vld) begin
                    w_shift_en = 1'b1;
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        w_next_state = PAR;
                    end
                end
            end
            PAR: begin
                if (bus.i_bit_vld) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (bus.i_bit_vld) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    sipo_shift #(
        .DATA_W (DATA_W),
        .IDX_W  (CNT_W)
    ) u_sipo_shift (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wr_en (w_shift_en),
        .i_idx   (r_cnt),
        .i_bit   (bus.i_x),
        .o_word  (w_word)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt          <= '0;
            r_par          <= 1'b0;
            r_par_err_pend <= 1'b0;
            r_data         <= '0;
            r_data_vld     <= 1'b0;
            r_par_err      <= 1'b0;
        end else begin
            r_data_vld <= 1'b0;
            if (bus.i_bit_vld) begin
                case (r_state)
                    IDLE: begin
                        if (!bus.i_x) begin
                            r_cnt <= '0;
                            r_par <= 1'b0;
                        end
                    end
                    DATA: begin
                        r_par <= r_par ^ bus.i_x;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    PAR: begin
                        // Even parity over data+parity: odd total flags an error.
                        r_par_err_pend <= r_par ^ bus.i_x;
                    end
                    STOP: begin
                        r_data     <= w_word;
                        r_par_err  <= r_par_err_pend;
                        r_data_vld <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef PARITY_FRAME_CHECK_STOP_EN
    logic r_frame_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_err <= 1'b0;
        end else if (bus.i_bit_vld && (r_state == STOP)) begin
            r_frame_err <= ~bus.i_x;
        end
    end

    assign bus.o_frame_err = r_frame_err;
`else
    assign bus.o_frame_err = 1'b0;
`endif

    assign bus.o_data     = r_data;
    assign bus.o_data_vld = r_data_vld;
    assign bus.o_par_err  = r_par_err;
    assign bus.o_busy     = (r_state != IDLE);

endmodule : parity_frame_checker
`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_parity_frame_checker                                      |
// | Description : Self-checking bench for parity_frame_checker. Frames are     |
// |               driven bit by bit; expected results are queued when the     |
// |               stop bit is driven and compared when o_data_vld pulses.     |
// |               Honors PARITY_FRAME_CHECK_STOP_EN for stop-bit expectations.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_parity_frame_checker;

    localparam int DW = 8;

`ifdef PARITY_FRAME_CHECK_STOP_EN
    localparam logic c_stop_chk = 1'b1;
`else
    localparam logic c_stop_chk = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
        logic          stop;
        logic          e_perr;
        logic          e_ferr;
    } vec_t;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    parity_frame_checker_if #(.DATA_W(DW)) bus ();

    parity_frame_checker #(.DATA_W(DW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_vld  = 0;
    int   cyc    = 0;
    exp_t sb[$];
    int   vcyc[$];
    exp_t hold = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard compare on each pulse, hold check otherwise.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst_n) begin
            hold = '0;
        end else if (bus.o_data_vld) begin
            n_vld++;
            vcyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_vld", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("data",      32'(bus.o_data),      32'(e.data));
                check("par_err",   32'(bus.o_par_err),   32'(e.perr));
                check("frame_err", 32'(bus.o_frame_err), 32'(e.ferr));
                hold = e;
            end
        end else begin
            check("hold", 32'({bus.o_data, bus.o_par_err, bus.o_frame_err}), 32'(hold));
        end
    end

    task automatic send_bit(input logic b);
        @(negedge i_clk);
        bus.i_x       = b;
        bus.i_bit_vld = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            bus.i_x       = 1'b1;
            bus.i_bit_vld = 1'b0;
        end
    endtask

    task automatic stall(input int n);
        repeat (n) begin
            @(negedge i_clk);
            bus.i_x       = 1'($urandom_range(0, 1));
            bus.i_bit_vld = 1'b0;
            check("busy_stall", 32'(bus.o_busy), 32'd1);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                              input logic e_perr, input logic e_ferr, input int stall_after);
        exp_t e;
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) begin
            send_bit(d[i]);
            if (i == stall_after) stall(3);
        end
        send_bit(p);
        e.data = d;
        e.perr = e_perr;
        e.ferr = e_ferr;
        sb.push_back(e);
        send_bit(s);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge i_clk);
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   n0;
        logic [DW-1:0] part;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, c_stop_chk};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{8'h7E, 1'b0, 1'b0, 1'b0, c_stop_chk};

        bus.i_x       = 1'b1;
        bus.i_bit_vld = 1'b0;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_data",      32'(bus.o_data),      32'd0);
        check("rst_data_vld",  32'(bus.o_data_vld),  32'd0);
        check("rst_par_err",   32'(bus.o_par_err),   32'd0);
        check("rst_frame_err", 32'(bus.o_frame_err), 32'd0);
        check("rst_busy",      32'(bus.o_busy),      32'd0);
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;

        // Table of frames, some back-to-back, some with a qualified idle bit
        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop,
                       vecs[i].e_perr, vecs[i].e_ferr, -1);
            if (i % 3 == 1) send_bit(1'b1);
        end
        idle(2);
        drain();
        check("busy_after_frames", 32'(bus.o_busy), 32'd0);

        // Stall of 3 cycles after data bit 4
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        idle(2);
        drain();

        // Reset mid-frame after 5 data bits, then a full 0x3C frame
        n0   = n_vld;
        part = 8'hA5;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(part[i]);
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        bus.i_bit_vld = 1'b0;
        @(negedge i_clk);
        check("midrst_data",  32'(bus.o_data),     32'd0);
        check("midrst_busy",  32'(bus.o_busy),     32'd0);
        check("midrst_vld",   32'(bus.o_data_vld), 32'd0);
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        idle(4);
        drain();
        check("midrst_vld_count", 32'(n_vld - n0), 32'd1);

        // Back-to-back frames with no gap
        vcyc.delete();
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        idle(3);
        drain();
        check("b2b_pulse_count", 32'(vcyc.size()), 32'd2);
        if (vcyc.size() == 2) begin
            check("b2b_spacing", 32'(vcyc[1] - vcyc[0]), 32'd11);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_parity_frame_checker
`default_nettype wire
